// File: rtl/mul_job_dispatcher_pkg.sv
// Shared types and defaults for the multiplier job dispatcher.
// Holds the FSM state encoding and the timer-width helper.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int MUL_BW      = 16;
  localparam int MUL_DEPTH   = 4;
  localparam int MUL_TIMEOUT = 1024;

  // Timer must reach TIMEOUT-1; keep at least one bit for tiny timeouts.
  function automatic int timer_w(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/mul_job_fifo.sv
// Operand-pair FIFO: wrap-bit pointers plus an occupancy count.
// Head entry is visible combinationally; no write-through bypass.
module mul_job_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic [AW:0]  count_q, count_d;
  logic         do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mul_job_dispatcher.sv
// Feeds an ST/RD handshaked multiplier from an operand FIFO, one job at a
// time, and returns each product (or a timeout error) on a result stream.
module mul_job_dispatcher
  import mul_pkg::*;
#(
  parameter int BW      = MUL_BW,
  parameter int DEPTH   = MUL_DEPTH,
  parameter int TIMEOUT = MUL_TIMEOUT
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [BW-1:0] IN_A,
  input  logic [BW-1:0] IN_B,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [BW-1:0] OUT_RES,
  output logic          OUT_ERR,
  output logic          M_ST,
  output logic [BW-1:0] M_IN0,
  output logic [BW-1:0] M_IN1,
  input  logic          M_RD,
  input  logic [BW-1:0] M_RES,
  output logic          BUSY
);

  localparam int            TW   = timer_w(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [BW-1:0]   in0_q, in0_d;
  logic [BW-1:0]   in1_q, in1_d;
  logic [BW-1:0]   res_q, res_d;
  logic            err_q, err_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [2*BW-1:0] fifo_head;
  logic            fifo_full, fifo_empty;
  logic            pop;

  mul_job_fifo #(
    .W     (2*BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .push_i  (IN_VALID),
    .wdata_i ({IN_A, IN_B}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      in0_q   <= '0;
      in1_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      in0_q   <= in0_d;
      in1_q   <= in1_d;
      res_q   <= res_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  // Operands are only reloaded on the IDLE->LAUNCH edge, so they stay put
  // for the whole recursion the multiplier runs on them.
  always_comb begin
    state_d = state_q;
    in0_d   = in0_q;
    in1_d   = in1_q;
    res_d   = res_q;
    err_d   = err_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = LAUNCH;
          in0_d   = fifo_head[2*BW-1:BW];
          in1_d   = fifo_head[BW-1:0];
          timer_d = '0;
        end
      end
      LAUNCH: begin
        if (timer_q == TMAX) begin
          state_d = DONE;
          res_d   = '0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
          if (!M_RD) state_d = RUN;
        end
      end
      RUN: begin
        if (M_RD) begin
          state_d = DONE;
          res_d   = M_RES;
          err_d   = 1'b0;
        end else if (timer_q == TMAX) begin
          state_d = DONE;
          res_d   = '0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Launch waits for M_RD high so a timed-out multiplier is never restarted.
  always_comb begin
    pop       = (state_q == IDLE) && !fifo_empty && M_RD;
    M_ST      = (state_q == LAUNCH);
    OUT_VALID = (state_q == DONE);
    BUSY      = (state_q != IDLE) || !fifo_empty;
    IN_READY  = !fifo_full;
    M_IN0     = in0_q;
    M_IN1     = in1_q;
    OUT_RES   = res_q;
    OUT_ERR   = err_q;
  end

endmodule
